// File: rtl/fp32_divider_seq.sv
// fp32_divider_seq: iterative FP32 divider, one quotient bit per clock, RNE.
// Define FP_DIV_FLAGS_EN to add the IEEE exception flags output.
module fp32_divider_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] k
`ifdef FP_DIV_FLAGS_EN
  ,
  output logic [4:0]  flags
`endif
);
  localparam int QBITS = 27;
  localparam int EXP_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    ROUND,
    DONE
  } state_t;

  state_t state;

  logic [QBITS-1:0] q;
  logic [24:0] rem;
  logic [23:0] mb;
  logic [4:0] cnt;
  logic sign;
  logic signed [EXP_W-1:0] e_r;

  logic x_zero, y_zero, x_inf, y_inf;
  logic x_nan, y_nan, sp_nan, special;
  logic [31:0] sp_k;

  assign x_zero = (x[30:23] == 8'h00);
  assign y_zero = (y[30:23] == 8'h00);
  assign x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  assign y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
  assign x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  assign y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);

  assign sp_nan = x_nan | y_nan | (x_zero & y_zero)
                | (x_inf & y_inf);
  assign special = sp_nan | x_inf | y_zero
                 | x_zero | y_inf;

  // Specials overlap, so evaluation order sets priority
  always_comb begin
    if (sp_nan)
      sp_k = 32'h7FC0_0000;
    else if (x_inf | y_zero)
      sp_k = {x[31] ^ y[31], 8'hFF, 23'd0};
    else
      sp_k = {x[31] ^ y[31], 31'd0};
  end

  logic [22:0] frac, frac_r;
  logic g, s, up, carry, ovf, unf;
  logic signed [EXP_W-1:0] e_n, e_f;
  logic [31:0] rnd_k;

  // Leading quotient bit is always 1 after normalisation
  always_comb begin
    if (q[QBITS-1]) begin
      frac = q[25:3];
      g    = q[2];
      s    = (|q[1:0]) | (|rem);
      e_n  = e_r;
    end else begin
      frac = q[24:2];
      g    = q[1];
      s    = q[0] | (|rem);
      e_n  = e_r - 10'sd1;
    end
    up     = g & (s | frac[0]);
    carry  = up & (&frac);
    frac_r = frac + {22'd0, up};
    e_f    = carry ? e_n + 10'sd1 : e_n;
    ovf    = (e_f >= 10'sd255);
    unf    = (e_f <= 10'sd0);
    if (ovf)
      rnd_k = {sign, 8'hFF, 23'd0};
    else if (unf)
      rnd_k = {sign, 31'd0};
    else
      rnd_k = {sign, e_f[7:0], frac_r};
  end

`ifdef FP_DIV_FLAGS_EN
  logic [4:0] sp_flags, rnd_flags;
  assign sp_flags = {sp_nan,
                     ~sp_nan & ~x_inf & y_zero,
                     3'b000};
  assign rnd_flags = {2'b00, ovf, unf,
                      g | s | ovf | unf};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      k         <= 32'd0;
      q         <= '0;
      rem       <= '0;
      mb        <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      e_r       <= '0;
`ifdef FP_DIV_FLAGS_EN
      flags     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            sign     <= x[31] ^ y[31];
            if (special) begin
              k     <= sp_k;
              state <= DONE;
`ifdef FP_DIV_FLAGS_EN
              flags <= sp_flags;
`endif
            end else begin
              mb    <= {1'b1, y[22:0]};
              rem   <= {2'b01, x[22:0]};
              q     <= '0;
              cnt   <= '0;
              e_r   <= $signed({2'b00, x[30:23]})
                     - $signed({2'b00, y[30:23]})
                     + 10'sd127;
              state <= DIVIDE;
`ifdef FP_DIV_FLAGS_EN
              flags <= '0;
`endif
            end
          end
        end
        DIVIDE: begin
          if (rem >= {1'b0, mb}) begin
            q   <= {q[QBITS-2:0], 1'b1};
            rem <= (rem - {1'b0, mb}) << 1;
          end else begin
            q   <= {q[QBITS-2:0], 1'b0};
            rem <= rem << 1;
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'(QBITS - 1))
            state <= ROUND;
        end
        ROUND: begin
          k         <= rnd_k;
          out_valid <= 1'b1;
          state     <= DONE;
`ifdef FP_DIV_FLAGS_EN
          flags     <= rnd_flags;
`endif
        end
        DONE: begin
          // Special results arrive with out_valid low for one clock
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_divider_seq.sv
// tb_fp32_divider_seq: directed vectors against an exact-arithmetic
// reference of FP32 division with round-to-nearest-even.
module tb_fp32_divider_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x, y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] k;
`ifdef FP_DIV_FLAGS_EN
  logic [4:0]  flags;
`endif

  fp32_divider_seq dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x(x),
    .y(y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .k(k)
`ifdef FP_DIV_FLAGS_EN
    ,
    .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] exp_k;
  logic [4:0]  exp_f;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // Reference: exact integer quotient of the significands, RNE on remainder
  function automatic void model(input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] r,
                                output logic [4:0] f);
    logic s;
    logic an, bn, ai, bi, az, bz;
    longint ma, mb, qq, rr;
    int e;
    logic inex;
    s  = a[31] ^ b[31];
    az = (a[30:23] == 0);
    bz = (b[30:23] == 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    f = 5'b0;
    if (an || bn || (az && bz) || (ai && bi)) begin
      r = 32'h7FC00000;
      f = 5'b10000;
    end else if (ai) begin
      r = {s, 8'hFF, 23'd0};
    end else if (bz) begin
      r = {s, 8'hFF, 23'd0};
      f = 5'b01000;
    end else if (az || bi) begin
      r = {s, 31'd0};
    end else begin
      ma = longint'({1'b1, a[22:0]});
      mb = longint'({1'b1, b[22:0]});
      e = int'(a[30:23]) - int'(b[30:23]) + 127;
      if (ma >= mb) begin
        qq = (ma << 23) / mb;
        rr = (ma << 23) % mb;
      end else begin
        qq = (ma << 24) / mb;
        rr = (ma << 24) % mb;
        e = e - 1;
      end
      inex = (rr != 0);
      if (2 * rr > mb || (2 * rr == mb && qq[0]))
        qq = qq + 1;
      if (qq == (longint'(1) << 24)) begin
        qq = longint'(1) << 23;
        e = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        f = 5'b00101;
      end else if (e <= 0) begin
        r = {s, 31'd0};
        f = 5'b00011;
      end else begin
        r = {s, 8'(e), qq[22:0]};
        f = {4'b0, inex};
      end
    end
  endfunction

  // Result checker: every cycle out_valid is high
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("k", k, exp_k);
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
`ifdef FP_DIV_FLAGS_EN
      chk("flags", {27'd0, flags}, {27'd0, exp_f});
`endif
    end
  end

  task automatic run(input logic [31:0] a,
                     input logic [31:0] b,
                     input int lat,
                     input int hold);
    int n;
    int acc;
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    model(a, b, exp_k, exp_f);
    x = a;
    y = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    // operands offered while busy must be ignored
    x = 32'h12345678;
    y = 32'h3F800000;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(cyc - acc), 32'(lat));
    repeat (hold) @(negedge clk);
    chk("out_valid_held", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("handoff_out_valid", {31'd0, out_valid}, 32'd0);
    chk("handoff_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  logic [31:0] mk;
  logic [4:0]  mf;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;

    // pin the reference model to hand-derived results
    model(32'h40C00000, 32'h40000000, mk, mf);
    chk("model_6_2", mk, 32'h40400000);
    chk("model_6_2_f", {27'd0, mf}, 32'h0);
    model(32'h3F800000, 32'h40400000, mk, mf);
    chk("model_1_3", mk, 32'h3EAAAAAB);
    chk("model_1_3_f", {27'd0, mf}, 32'h1);
    model(32'hBF800000, 32'h00000000, mk, mf);
    chk("model_dz", mk, 32'hFF800000);
    chk("model_dz_f", {27'd0, mf}, 32'h8);
    model(32'h00000000, 32'h00000000, mk, mf);
    chk("model_nan", mk, 32'h7FC00000);
    model(32'h7F000000, 32'h3E800000, mk, mf);
    chk("model_ovf", mk, 32'h7F800000);
    chk("model_ovf_f", {27'd0, mf}, 32'h5);
    model(32'h00800000, 32'h41000000, mk, mf);
    chk("model_unf", mk, 32'h00000000);
    chk("model_unf_f", {27'd0, mf}, 32'h3);

    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_k", k, 32'd0);
`ifdef FP_DIV_FLAGS_EN
    chk("rst_flags", {27'd0, flags}, 32'd0);
`endif
    rst_n = 1'b1;

    run(32'h40C00000, 32'h40000000, 28, 2);
    run(32'h3F800000, 32'h40400000, 28, 2);
    run(32'hBF800000, 32'h00000000, 1, 2);
    run(32'h00000000, 32'h00000000, 1, 2);
    run(32'h7F000000, 32'h3E800000, 28, 2);
    run(32'h00800000, 32'h41000000, 28, 2);
    run(32'hC0A00000, 32'h40400000, 28, 2);
    run(32'h7FC00001, 32'h3F800000, 1, 1);
    run(32'hFF800000, 32'h40000000, 1, 1);
    run(32'h40000000, 32'hFF800000, 1, 1);
    run(32'h3F7FFFFF, 32'h3F800001, 28, 1);
    run(32'h40C00000, 32'h40000000, 28, 10);

    // abort an operation in the middle of the iteration
    @(negedge clk);
    x = 32'h40C00000;
    y = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_k", k, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(32'h40C00000, 32'h40000000, 28, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
